passcode_checker: RTL
=====================

PASSCODE_CHECKER -- requirements
Module: passcode_checker

Interface
REQ-001 Parameters SHALL be:
- CODE0..CODE3: default 4'd1, 4'd2, 4'd3, 4'd4; secret digits in entry order.
- TIMEOUT_CYCLES: default 250000000; idle limit between digits (5 s at 50 MHz).
- LOCKOUT_CYCLES: default 500000000; lockout length (10 s at 50 MHz).
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be:
- clock  in  1  50 MHz system clock.
- reset  in  1  asynchronous active-high reset.
- armed  in  1  high while system state is SET or TRIGGER.
- key_valid  in  1  single-cycle key-press strobe.
- key_digit  in  4  pressed digit, qualified by key_valid.
- passcode_state  out  3  progress code consumed by the display stage.
- unlock  out  1  one-cycle pulse on full correct entry.
- error  out  1  one-cycle pulse on wrong digit or timeout.
- locked  out  1  high during lockout.

Function
REQ-004 passcode_state encoding SHALL be sIdle=0, sDig1Corr=1, sDig2Corr=2, sDig3Corr=3, sDig4Corr=4; values 5-7 SHALL never appear.
REQ-005 Internal FSM states SHALL be IDLE, D1, D2, D3, D4 and LOCK. passcode_state SHALL be 0 in both IDLE and LOCK.
REQ-006 All outputs SHALL be registered. A key accepted in cycle N SHALL be reflected on the outputs in cycle N+1.
REQ-007 In state Dk (k=0 means IDLE, k=0..3), key_valid with key_digit==CODEk SHALL advance to D(k+1).
REQ-008 A key_digit greater than 9 SHALL be treated as wrong.
REQ-009 A wrong digit in IDLE..D3 SHALL return the FSM to IDLE and pulse error for 1 cycle. The wrong digit SHALL NOT be re-evaluated as a first digit.
REQ-010 Entering D4 SHALL pulse unlock for exactly 1 cycle, coincident with passcode_state becoming 4.
REQ-011 D4 SHALL hold until armed deasserts. key_valid SHALL be ignored in D4.
REQ-012 Inter-key timer:
- cleared on every accepted key and on every state change;
- counts each cycle in D1..D3.
REQ-013 When the timer reaches TIMEOUT_CYCLES-1, the FSM SHALL go to IDLE and pulse error. If key_valid arrives in that same cycle, the key SHALL win.
REQ-014 A 2-bit consecutive-failure counter SHALL increment on each error pulse and clear on unlock.
REQ-015 The third consecutive failure SHALL enter LOCK instead of IDLE, assert locked, and clear the failure counter. That cycle SHALL still pulse error.
REQ-016 In LOCK, key_valid SHALL be ignored. After LOCKOUT_CYCLES cycles the FSM SHALL go to IDLE and deassert locked.
REQ-017 armed low SHALL force IDLE on the next edge from any state except LOCK. It SHALL also clear the timer and the failure counter and suppress unlock/error pulses.
REQ-018 LOCK SHALL continue independently of armed.
REQ-019 Timer and lockout counters SHALL be 30 bits wide and SHALL saturate, never wrap.
REQ-020 Simultaneous armed falling and key_valid: armed SHALL take priority and the key SHALL be discarded.
REQ-021 unlock and error SHALL never be high in the same cycle.

Reset
REQ-022 While reset is high: FSM=IDLE, passcode_state=0, unlock=0, error=0, locked=0, all counters 0.
REQ-023 Reset mid-entry or mid-lockout SHALL abort immediately, asynchronously.
REQ-024 After reset release, the first accepted key SHALL be evaluated from the first clock edge.

Verification (TIMEOUT_CYCLES=20, LOCKOUT_CYCLES=40)
REQ-025 armed=1; keys 1,2,3,4 -> passcode_state steps 1,2,3,4, each one cycle after its key; unlock=1 for one cycle with state 4; error never asserted.
REQ-026 armed=1; keys 1,2,7 -> state 1,2 then 0; error pulse one cycle after the 7; next keys 1,2,3,4 -> unlock.
REQ-027 armed=1; key 1, then no key for 20 cycles -> state returns 0 with error pulse; a key 2 in exactly cycle 19 instead -> state 2, no error.
REQ-028 armed=1; three wrong keys (9,9,9) -> locked=1 after the third; keys 1,2,3,4 during lockout ignored (state 0); locked=0 after 40 cycles; then 1,2,3,4 -> unlock.
REQ-029 armed=1; keys 1,2,3, then armed=0 in the same cycle as key 4 -> state 0, no unlock. Separately, reset asserted in state 3 -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/passcode_checker.sv
// passcode_checker: four-digit keypad passcode FSM with an inter-key timeout,
// consecutive-failure counting and a timed lockout. All outputs are registered.
//
// Key interface: key_valid is a single-cycle strobe and key_digit is only
// meaningful while key_valid is high. There is no ready/backpressure: every
// strobe is consumed on the edge it is sampled (or deliberately discarded in
// D4, in LOCK, or while armed is low).
module passcode_checker #(
  parameter logic [3:0]  CODE0          = 4'd1,
  parameter logic [3:0]  CODE1          = 4'd2,
  parameter logic [3:0]  CODE2          = 4'd3,
  parameter logic [3:0]  CODE3          = 4'd4,
  parameter int unsigned TIMEOUT_CYCLES = 250000000,
  parameter int unsigned LOCKOUT_CYCLES = 500000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       armed,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic [2:0] passcode_state,
  output logic       unlock,
  output logic       error,
  output logic       locked
);

  // D1..D4 share their encoding with the externally visible progress code.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    D1   = 3'd1,
    D2   = 3'd2,
    D3   = 3'd3,
    D4   = 3'd4,
    LOCK = 3'd5
  } state_t;

  localparam logic [29:0] TO_LAST  = 30'(TIMEOUT_CYCLES - 1);
  localparam logic [29:0] LK_LAST  = 30'(LOCKOUT_CYCLES - 1);
  localparam logic [29:0] CNT_SAT  = '1;

  state_t      state_q, state_d;
  logic [29:0] timer_q, timer_d;
  logic [29:0] lock_cnt_q, lock_cnt_d;
  logic [1:0]  fail_q, fail_d;
  logic [2:0]  pstate_q, pstate_d;
  logic        unlock_q, unlock_d;
  logic        error_q, error_d;
  logic        locked_q, locked_d;

  logic [3:0]  exp_digit;
  logic        digit_ok;
  logic        in_entry;
  logic        timed_out;
  logic        take_fail;

  // Expected digit for the current position; digits above 9 never match.
  always_comb begin
    exp_digit = CODE3;
    case (state_q)
      IDLE:    exp_digit = CODE0;
      D1:      exp_digit = CODE1;
      D2:      exp_digit = CODE2;
      default: exp_digit = CODE3;
    endcase
    digit_ok  = (key_digit <= 4'd9) && (key_digit == exp_digit);
    in_entry  = (state_q == D1) || (state_q == D2) || (state_q == D3);
    timed_out = in_entry && (timer_q == TO_LAST);
  end

  // Next-state, counters and output pulses; armed-low beats keys, keys beat timeout.
  always_comb begin
    state_d    = state_q;
    fail_d     = fail_q;
    unlock_d   = 1'b0;
    error_d    = 1'b0;
    take_fail  = 1'b0;
    timer_d    = '0;
    lock_cnt_d = '0;

    if (state_q == LOCK) begin
      if (lock_cnt_q == LK_LAST) state_d = IDLE;
    end else if (!armed) begin
      state_d = IDLE;
      fail_d  = 2'd0;
    end else if (state_q == D4) begin
      state_d = D4;
    end else if (key_valid) begin
      if (digit_ok) begin
        state_d = state_t'(state_q + 3'd1);
        if (state_q == D3) begin
          unlock_d = 1'b1;
          fail_d   = 2'd0;
        end
      end else begin
        take_fail = 1'b1;
      end
    end else if (timed_out) begin
      take_fail = 1'b1;
    end

    // The third consecutive failure diverts to LOCK and restarts the count.
    if (take_fail) begin
      error_d = 1'b1;
      if (fail_q == 2'd2) begin
        state_d = LOCK;
        fail_d  = 2'd0;
      end else begin
        state_d = IDLE;
        fail_d  = fail_q + 2'd1;
      end
    end

    // Inter-key timer only runs while parked in D1..D3; any move clears it.
    if (in_entry && (state_d == state_q) && armed && (timer_q != CNT_SAT))
      timer_d = timer_q + 30'd1;
    else if (in_entry && (state_d == state_q) && armed)
      timer_d = timer_q;

    // Lockout counter runs only while remaining in LOCK.
    if ((state_q == LOCK) && (state_d == LOCK))
      lock_cnt_d = (lock_cnt_q != CNT_SAT) ? lock_cnt_q + 30'd1 : lock_cnt_q;

    pstate_d = (state_d == LOCK) ? 3'd0 : 3'(state_d);
    locked_d = (state_d == LOCK);
  end

  // State and registered outputs; reset aborts anything immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      lock_cnt_q <= '0;
      fail_q     <= 2'd0;
      pstate_q   <= 3'd0;
      unlock_q   <= 1'b0;
      error_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      lock_cnt_q <= lock_cnt_d;
      fail_q     <= fail_d;
      pstate_q   <= pstate_d;
      unlock_q   <= unlock_d;
      error_q    <= error_d;
      locked_q   <= locked_d;
    end
  end

  assign passcode_state = pstate_q;
  assign unlock         = unlock_q;
  assign error          = error_q;
  assign locked         = locked_q;

endmodule
